out_display_driver: RTL
=======================

Name: out_display_driver

Overview:
- Downstream consumer of the machine's output register.
- Captures the 8-bit OUT value when it is written, converts it to decimal with a sequential double-dabble engine, and drives a multiplexed 4-digit 7-segment display: sign, hundreds, tens, units.
- Supports unsigned mode and two's-complement signed mode.

Parameters:
SCAN_DIV, 4, clock cycles each digit stays enabled before the scan advances; legal range >= 1.

Ports:
clk  input  1  system clock; all state changes on posedge
reset  input  1  asynchronous, active-high; clears all state immediately
value  input  8  OUT register contents
load  input  1  capture strobe; high for the cycle in which OUT is written (tie to en_write_out)
signed_mode  input  1  1 = interpret value as two's complement; sampled together with value on load
digit_en  output  4  one-hot active-high digit enable; bit0 = units, bit1 = tens, bit2 = hundreds, bit3 = sign
segments  output  7  active-high segments {a,b,c,d,e,f,g}, bit6 = a, bit0 = g
busy  output  1  high while a conversion is in progress

Behaviour:
- Reset (asynchronous, active-high):
  - FSM returns to IDLE; busy = 0; pending flag cleared.
  - Displayed BCD = 000, sign = 0.
  - Scan index = 0, scan divider = 0, digit_en = 4'b0001, segments = 7'b1111110 (a "0" on the units digit).
  - Reset asserted mid-conversion aborts the conversion; the displayed value becomes 0.
- Capture:
  - On a posedge with load = 1 in IDLE, latch value and signed_mode.
  - Magnitude rules:
    - signed_mode = 1 and value[7] = 1: magnitude = (~value + 1), 8 bits unsigned, and the negative flag is set. 0x80 gives 128.
    - Otherwise: magnitude = value, negative = 0.
- FSM states IDLE -> CONVERT -> COMMIT -> IDLE:
  - IDLE: busy = 0.
  - CONVERT: busy = 1. There are exactly 8 iterations, one per clock. Each iteration first adds 3 to every BCD nibble that is >= 5, then shifts {bcd[11:0], mag[7:0]} left by 1. An iteration counter runs 0..7 and leaves for COMMIT after iteration 7.
  - COMMIT: busy = 1. Copy BCD and the negative flag into the display registers, then go to IDLE.
- Latency:
  - load is sampled at edge E0.
  - busy is high after E0.
  - The display registers update at E0 + 9, and busy is low after that edge.
- Load while busy:
  - The new value and signed_mode go into a one-deep pending slot; a later load overwrites it (latest wins).
  - At the COMMIT edge, if the pending flag is set, the FSM goes directly to CONVERT with the pending data and clears the flag. busy stays high with no idle gap.
- Load in the COMMIT cycle is treated as pending, same as any load while busy.
- The display registers change only at COMMIT. They never show a partial result.
- Scan:
  - The divider counts 0..SCAN_DIV-1.
  - On wrap, the scan index advances 0 -> 1 -> 2 -> 3 -> 0.
  - digit_en = one-hot(index).
  - The scan runs continuously and is independent of the FSM.
- Segment select for the current index:
  - Units: always shows its digit.
  - Tens: blank when hundreds = 0 and tens = 0.
  - Hundreds: blank when hundreds = 0.
  - Sign: minus pattern 7'b0000001 when negative, else blank 7'b0000000.
- Digit encodings, {a..g}:
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011
  - 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1111011
- Registered outputs: digit_en and segments are registered together and always change on the same edge.
- BCD range: maximum unsigned value is 255 and maximum signed magnitude is 128, so the hundreds nibble never exceeds 2.

Test Plan:
- Reset, then no load, with SCAN_DIV = 4 -> digit_en cycles 0001, 0010, 0100, 1000, each held 4 cycles. Segments: units 1111110, all other digits 0000000.
- load with value = 8'd233, signed_mode = 0 -> busy high for 9 cycles. Then hundreds = 1101101, tens = 1111001, units = 1111001, sign blank.
- load with value = 8'hF9, signed_mode = 1 -> display shows -7: sign 0000001, units 1110000, tens and hundreds blank. Repeat with value = 8'h80 -> -128.
- load 8'd5, then load 8'd42 three cycles later, then load 8'd99 two cycles after that -> display shows 5 at E0 + 9, then 99 exactly 9 cycles after that (42 discarded). busy stays high throughout.
- Assert reset at iteration 4 of converting 8'd200 -> outputs return to their reset values immediately, without waiting for a clock edge. The next load of 8'd7 displays 7 after 9 cycles.
- Unsigned sweep 0..255 with signed_mode = 0 and signed sweep with signed_mode = 1 -> the decoded digits match a decimal reference model for every value, with correct blanking and sign.

Source files
------------

// File: rtl/out_display_driver_if.sv
// ---------------------------------------------------------------------------
// out_display_driver_if : OUT-register capture inputs and display-side outputs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface out_display_driver_if;
  logic [7:0] value;
  logic       load;
  logic       signed_mode;
  logic [3:0] digit_en;
  logic [6:0] segments;
  logic       busy;

  modport master (
    output value, load, signed_mode,
    input  digit_en, segments, busy
  );

  modport slave (
    input  value, load, signed_mode,
    output digit_en, segments, busy
  );
endinterface

`default_nettype wire

// File: rtl/out_display_driver.sv
// ---------------------------------------------------------------------------
// out_display_driver : OUT value -> double-dabble BCD -> muxed 4-digit 7-seg
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module out_display_driver #(
  parameter int SCAN_DIV = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  out_display_driver_if.slave  bus
);

  localparam int               DIV_W       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] c_div_last  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] c_div_one   = DIV_W'(1);
  localparam logic [6:0]       c_seg_blank = 7'b0000000;
  localparam logic [6:0]       c_seg_minus = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        iter_q, iter_d;
  logic [7:0]        mag_q, mag_d;
  logic [11:0]       bcd_q, bcd_d;
  logic              neg_q, neg_d;
  logic              pend_q, pend_d;
  logic [7:0]        pend_value_q, pend_value_d;
  logic              pend_signed_q, pend_signed_d;
  logic [11:0]       disp_bcd_q, disp_bcd_d;
  logic              disp_neg_q, disp_neg_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        digit_en_q, digit_en_d;
  logic [6:0]        segments_q, segments_d;

  logic              w_start;
  logic [7:0]        w_src_value;
  logic              w_src_signed;
  logic [11:0]       w_adj;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1111110;
      4'd1:    seg_of = 7'b0110000;
      4'd2:    seg_of = 7'b1101101;
      4'd3:    seg_of = 7'b1111001;
      4'd4:    seg_of = 7'b0110011;
      4'd5:    seg_of = 7'b1011011;
      4'd6:    seg_of = 7'b1011111;
      4'd7:    seg_of = 7'b1110000;
      4'd8:    seg_of = 7'b1111111;
      4'd9:    seg_of = 7'b1111011;
      default: seg_of = c_seg_blank;
    endcase
  endfunction

  function automatic logic [3:0] dd_adj(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  always_comb begin
    state_d       = state_q;
    iter_d        = iter_q;
    mag_d         = mag_q;
    bcd_d         = bcd_q;
    neg_d         = neg_q;
    pend_d        = pend_q;
    pend_value_d  = pend_value_q;
    pend_signed_d = pend_signed_q;
    disp_bcd_d    = disp_bcd_q;
    disp_neg_d    = disp_neg_q;
    div_d         = div_q;
    idx_d         = idx_q;
    digit_en_d    = digit_en_q;
    segments_d    = segments_q;
    w_start       = 1'b0;
    // A load on this very edge is newer than anything in the pending slot.
    w_src_value   = bus.load ? bus.value       : pend_value_q;
    w_src_signed  = bus.load ? bus.signed_mode : pend_signed_q;
    w_adj         = {dd_adj(bcd_q[11:8]), dd_adj(bcd_q[7:4]), dd_adj(bcd_q[3:0])};

    case (state_q)
      ST_IDLE: begin
        w_start = bus.load | pend_q;
      end
      ST_CONVERT: begin
        bcd_d  = {w_adj[10:0], mag_q[7]};
        mag_d  = {mag_q[6:0], 1'b0};
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) begin
          state_d = ST_COMMIT;
        end
        if (bus.load) begin
          pend_d        = 1'b1;
          pend_value_d  = bus.value;
          pend_signed_d = bus.signed_mode;
        end
      end
      ST_COMMIT: begin
        disp_bcd_d = bcd_q;
        disp_neg_d = neg_q;
        state_d    = ST_IDLE;
        w_start    = bus.load | pend_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (w_start) begin
      state_d = ST_CONVERT;
      iter_d  = 3'd0;
      bcd_d   = 12'd0;
      pend_d  = 1'b0;
      neg_d   = w_src_signed & w_src_value[7];
      mag_d   = neg_d ? (~w_src_value + 8'd1) : w_src_value;
    end

    if (div_q == c_div_last) begin
      div_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      div_d = div_q + c_div_one;
    end

    // Outputs are built from next-state values so they track index and display in lockstep.
    digit_en_d = 4'b0001 << idx_d;
    case (idx_d)
      2'd0:    segments_d = seg_of(disp_bcd_d[3:0]);
      2'd1:    segments_d = (disp_bcd_d[11:4] == 8'd0) ? c_seg_blank : seg_of(disp_bcd_d[7:4]);
      2'd2:    segments_d = (disp_bcd_d[11:8] == 4'd0) ? c_seg_blank : seg_of(disp_bcd_d[11:8]);
      default: segments_d = disp_neg_d ? c_seg_minus : c_seg_blank;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      iter_q        <= 3'd0;
      mag_q         <= 8'd0;
      bcd_q         <= 12'd0;
      neg_q         <= 1'b0;
      pend_q        <= 1'b0;
      pend_value_q  <= 8'd0;
      pend_signed_q <= 1'b0;
      disp_bcd_q    <= 12'd0;
      disp_neg_q    <= 1'b0;
      div_q         <= '0;
      idx_q         <= 2'd0;
      digit_en_q    <= 4'b0001;
      segments_q    <= 7'b1111110;
    end else begin
      state_q       <= state_d;
      iter_q        <= iter_d;
      mag_q         <= mag_d;
      bcd_q         <= bcd_d;
      neg_q         <= neg_d;
      pend_q        <= pend_d;
      pend_value_q  <= pend_value_d;
      pend_signed_q <= pend_signed_d;
      disp_bcd_q    <= disp_bcd_d;
      disp_neg_q    <= disp_neg_d;
      div_q         <= div_d;
      idx_q         <= idx_d;
      digit_en_q    <= digit_en_d;
      segments_q    <= segments_d;
    end
  end

  assign bus.digit_en = digit_en_q;
  assign bus.segments = segments_q;
  assign bus.busy     = (state_q != ST_IDLE);

endmodule

`default_nettype wire
